// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory store and load paths:
// access size codes, drain-state encoding and byte-enable width.
package cpu_mem_pkg;

  localparam int BE_W = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drain_state_t;

endpackage

// File: rtl/store_align.sv
// Little-endian lane alignment of a right-justified store; purely combinational, zero latency.
// No handshake: flags illegal size/offset combinations via misaligned.
module store_align
  import cpu_mem_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic [31:0]     data,
  output logic [BE_W-1:0] be,
  output logic [31:0]     wdata,
  output logic            misaligned
);

  always_comb begin
    be         = '0;
    wdata      = data;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{data[15:0]}};
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        be         = 4'b1111;
        misaligned = |addr_lo;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO draining aligned stores to memory; mem_req rises the cycle after a push into an empty buffer.
// st_ready drops when full; loads matching a pending word raise ld_hazard.
module store_buffer
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [31:0]              st_data,
  input  logic [1:0]               st_size,
  input  logic                     ld_check,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hazard,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [BE_W-1:0]          mem_be,
  input  logic                     mem_ack,
  output logic                     misalign_err,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-3:0] ent_addr [DEPTH];
  logic [31:0]       ent_data [DEPTH];
  logic [BE_W-1:0]   ent_be   [DEPTH];
  logic [PTR_W-1:0]  ent_off  [DEPTH];
  logic [DEPTH-1:0]  ent_hit;

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_next;
  logic              full;
  logic              push;
  logic              pop;

  logic [BE_W-1:0]   al_be;
  logic [31:0]       al_wdata;
  logic              al_mis;

  drain_state_t      state;
  drain_state_t      state_next;

  store_align u_align (
    .addr_lo    (st_addr[1:0]),
    .size       (st_size),
    .data       (st_data),
    .be         (al_be),
    .wdata      (al_wdata),
    .misaligned (al_mis)
  );

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign st_ready   = !full;
  assign push       = st_valid && st_ready && !al_mis;
  assign pop        = (state == REQ) && mem_ack;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_be[i]   <= '0;
      end
    end else begin
      count        <= count_next;
      misalign_err <= st_valid && st_ready && al_mis;
      if (push) begin
        ent_addr[wr_ptr] <= st_addr[ADDR_W-1:2];
        ent_data[wr_ptr] <= al_wdata;
        ent_be[wr_ptr]   <= al_be;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Entering REQ on the push edge itself gives single-cycle push-to-request latency.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count_next != '0) state_next = REQ;
      REQ:     if (count_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_req   = (state == REQ);
  assign mem_addr  = mem_req ? {ent_addr[rd_ptr], 2'b00} : '0;
  assign mem_wdata = mem_req ? ent_data[rd_ptr] : '0;
  assign mem_be    = mem_req ? ent_be[rd_ptr] : '0;

  // An entry is live when its distance from the head is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hazard
    assign ent_off[i] = PTR_W'(i) - rd_ptr;
    assign ent_hit[i] = ({1'b0, ent_off[i]} < count) &&
                        (ent_addr[i] == ld_addr[ADDR_W-1:2]);
  end

  assign ld_hazard = ld_check && (|ent_hit);

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based reference model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        ld_check;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        misalign_err;
  logic        empty;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  ent_t drained[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic exp_err = 1'b0;
  logic last_acc = 1'b0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_size(st_size),
    .ld_check(ld_check), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack),
    .misalign_err(misalign_err), .empty(empty), .count(count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference alignment straight from the little-endian lane rules.
  task automatic model_align(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                             output ent_t e, output logic mis);
    e.addr = {a[31:2], 2'b00};
    e.data = d;
    e.be   = 4'b0000;
    mis    = 1'b0;
    case (sz)
      2'b00: begin
        e.be   = 4'(1 << a[1:0]);
        e.data = {d[7:0], d[7:0], d[7:0], d[7:0]};
      end
      2'b01: begin
        e.be   = a[1] ? 4'b1100 : 4'b0011;
        e.data = {d[15:0], d[15:0]};
        mis    = a[0];
      end
      2'b10: begin
        e.be = 4'b1111;
        mis  = (a[1:0] != 2'b00);
      end
      default: mis = 1'b1;
    endcase
  endtask

  // One clock cycle: drive, check outputs mid-cycle, advance model to the next edge.
  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                     input logic ack, input logic lc, input logic [31:0] la);
    ent_t e;
    logic mis;
    logic hz;
    st_valid = v; st_addr = a; st_data = d; st_size = sz;
    mem_ack = ack; ld_check = lc; ld_addr = la;
    @(negedge clk);
    check("count", 32'(count), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
    check("mem_req", 32'(mem_req), 32'(q.size() != 0));
    check("misalign_err", 32'(misalign_err), 32'(exp_err));
    hz = 1'b0;
    foreach (q[k]) if (q[k].addr[31:2] == la[31:2]) hz = 1'b1;
    check("ld_hazard", 32'(ld_hazard), 32'(lc && hz));
    if (q.size() != 0) begin
      check("mem_addr", mem_addr, q[0].addr);
      check("mem_wdata", mem_wdata, q[0].data);
      check("mem_be", 32'(mem_be), 32'(q[0].be));
    end
    model_align(a, d, sz, e, mis);
    last_acc = v && (q.size() < DEPTH) && !mis;
    exp_err  = v && (q.size() < DEPTH) && mis;
    if (q.size() != 0 && ack) begin
      drained.push_back(q[0]);
      void'(q.pop_front());
    end
    if (last_acc) q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ack);
    cyc(1'b0, 32'h0, 32'h0, 2'b10, ack, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    ld_check = 1'b0; ld_addr = '0; mem_ack = 1'b0;
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_st_ready", 32'(st_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Word store, request on the next cycle, acked there.
    cyc(1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 32'h0);
    check("word_req", 32'(mem_req), 32'd1);
    check("word_addr", mem_addr, 32'h100);
    check("word_be", 32'(mem_be), 32'hF);
    check("word_data", mem_wdata, 32'hDEADBEEF);
    idle(1'b1);
    check("word_empty", 32'(empty), 32'd1);

    // Byte and halfword lane placement.
    cyc(1'b1, 32'h203, 32'h000000A5, 2'b00, 1'b0, 1'b0, 32'h0);
    check("byte_addr", mem_addr, 32'h200);
    check("byte_be", 32'(mem_be), 32'h8);
    check("byte_data", mem_wdata, 32'hA5A5A5A5);
    cyc(1'b1, 32'h202, 32'h00001234, 2'b01, 1'b1, 1'b0, 32'h0);
    check("half_be", 32'(mem_be), 32'hC);
    check("half_data", mem_wdata, 32'h12341234);
    idle(1'b1);
    idle(1'b0);

    // Five stores into four entries; the fifth waits for the first ack.
    drained.delete();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h400 + 32'(4 * i), 32'(i + 1), 2'b10, 1'b0, 1'b0, 32'h0);
    check("full_ready", 32'(st_ready), 32'd0);
    begin
      logic pend = 1'b1;
      for (int i = 0; i < 8; i++) begin
        cyc(pend, 32'h410, 32'd5, 2'b10, 1'b1, 1'b0, 32'h0);
        if (last_acc) pend = 1'b0;
      end
    end
    check("drain_count", 32'(drained.size()), 32'd5);
    foreach (drained[k]) check("drain_order", drained[k].addr, 32'h400 + 32'(4 * k));

    // Rejected stores pulse misalign_err and never reach memory.
    cyc(1'b1, 32'h102, 32'h11111111, 2'b10, 1'b0, 1'b0, 32'h0);
    check("mis_word_err", 32'(misalign_err), 32'd1);
    cyc(1'b1, 32'h100, 32'h22222222, 2'b11, 1'b0, 1'b0, 32'h0);
    check("mis_rsv_err", 32'(misalign_err), 32'd1);
    check("mis_count", 32'(count), 32'd0);
    idle(1'b0);
    check("mis_err_clear", 32'(misalign_err), 32'd0);
    check("mis_no_req", 32'(mem_req), 32'd0);

    // Load hazard against a pending word.
    cyc(1'b1, 32'h304, 32'hCAFEF00D, 2'b10, 1'b0, 1'b0, 32'h0);
    ld_check = 1'b1; ld_addr = 32'h306; #1;
    check("hz_hit", 32'(ld_hazard), 32'd1);
    ld_addr = 32'h308; #1;
    check("hz_miss", 32'(ld_hazard), 32'd0);
    cyc(1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 1'b1, 32'h306);
    ld_check = 1'b1; ld_addr = 32'h306; #1;
    check("hz_retired", 32'(ld_hazard), 32'd0);
    ld_check = 1'b0;

    // Reset in the middle of a transfer.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h500 + 32'(4 * i), 32'(i), 2'b10, 1'b0, 1'b0, 32'h0);
    st_valid = 1'b0; mem_ack = 1'b0;
    check("pre_rst_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_req", 32'(mem_req), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    q.delete();
    exp_err = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(1'b1, 32'h600, 32'h0BADF00D, 2'b10, 1'b0, 1'b0, 32'h0);
    check("post_rst_addr", mem_addr, 32'h600);
    idle(1'b1);
    idle(1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 9) < 6, 32'h300 + 32'($urandom_range(0, 31)), $urandom,
          2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, 32'h300 + 32'($urandom_range(0, 31)));
    end
    for (int i = 0; i < 6; i++) idle(1'b1);
    check("final_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the CPU store path and data memory, the write-side counterpart of the load/writeback path. It accepts byte, halfword and word stores and converts each to a word-aligned address, byte lanes and byte enables. Up to DEPTH stores are queued and drained to memory over a req/ack handshake. Loads compare their word address against all pending stores and raise a hazard so the pipeline can stall until that store retires.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ADDR_W, 32: address width.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- st_valid  in  1  store request.
- st_ready  out  1  buffer can accept; equals !full.
- st_addr  in  ADDR_W  byte address.
- st_data  in  32  store data, right-justified.
- st_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- ld_check  in  1  load address valid this cycle.
- ld_addr  in  ADDR_W  load byte address.
- ld_hazard  out  1  load word-address matches a pending store.
- mem_req  out  1  write request to data memory.
- mem_addr  out  ADDR_W  word-aligned address; bits [1:0] = 0.
- mem_wdata  out  32  lane-aligned data.
- mem_be  out  4  byte enables; bit i enables bits [8i+7:8i].
- mem_ack  in  1  memory accepted the write.
- misalign_err  out  1  one-cycle pulse for a rejected store.
- empty  out  1  no pending stores.
- count  out  $clog2(DEPTH)+1  number of pending entries.

## Operation
- Push: a store is pushed when st_valid && st_ready is sampled at a clock edge.
- Alignment is little-endian:
  - byte: mem_be = 1 << addr[1:0]; data byte replicated to all four lanes.
  - half: mem_be = addr[1] ? 1100 : 0011; halfword replicated to both halves.
  - word: mem_be = 1111.
- Misaligned stores are rejected:
  - Cases: half with addr[0] = 1, word with addr[1:0] != 0, or size 11.
  - A rejected store is not enqueued, and count is unchanged.
  - misalign_err is high for the following cycle.
  - st_ready is unaffected.
- Drain FSM has two states:
  - IDLE: go to REQ when !empty.
  - REQ: mem_req = 1, and mem_addr, mem_wdata and mem_be come from the head entry, held stable until mem_ack.
  - On mem_ack in REQ: pop the head. Stay in REQ if entries remain after the pop, otherwise go to IDLE.
  - mem_ack is ignored in IDLE.
- Push and pop in the same cycle: both take effect and count is unchanged.
  - This applies only when not full. A push while full is blocked even if a pop occurs that cycle.
- ld_hazard is combinational: ld_check && (some valid entry, including the in-flight head, has addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]). It is 0 when ld_check = 0.
- Pointer wrap: read and write pointers are modulo DEPTH. Full and empty are derived from count.

## Timing
- Reset values: count = 0, empty = 1, st_ready = 1, mem_req = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0, misalign_err = 0, state = IDLE, pointers = 0.
- Reset asserted mid-transfer:
  - mem_req drops immediately (asynchronously).
  - All pending stores are discarded.
  - The memory must ignore any ack in flight.
- Latency, push to first mem_req:
  - From empty, mem_req is high on the cycle after the push edge.
  - One write retires per cycle while mem_ack is held high.
- st_ready, empty and count are registered-state outputs. They update on the edge after push or pop.
- ld_hazard has zero latency. A store pushed at edge N is visible to the hazard check from cycle N+1. It is cleared after its ack edge.

## Structure
- Shared package cpu_mem_pkg holds:
  - Size codes SZ_BYTE, SZ_HALF, SZ_WORD.
  - The drain-state enum (IDLE, REQ).
  - The byte-enable width constant.
- Sub-module store_align: combinational alignment. Inputs are addr[1:0], size and data. Outputs are be, wdata and misaligned. It is reusable by the load-extract path.

## Test plan
- After reset, a word store at 0x100 with data 0xDEADBEEF and ack on the next cycle → mem_req high one cycle later, mem_addr = 0x100, mem_be = 1111, mem_wdata = 0xDEADBEEF. Then empty = 1.
- Byte store at 0x203 with data 0x000000A5 → mem_addr = 0x200, mem_be = 1000, mem_wdata = 0xA5A5A5A5. Halfword at 0x202 with data 0x1234 → mem_be = 1100, mem_wdata = 0x12341234.
- Push 5 stores with mem_ack = 0 and DEPTH = 4 → st_ready = 0 after the 4th. The 5th is held off until the first ack. Writes drain in order with no loss or duplication.
- Word store at 0x102, and size 11 at 0x100 → misalign_err pulses one cycle for each. count stays 0 and mem_req is never raised.
- Pending store at 0x304; load at 0x306 → ld_hazard = 1. Load at 0x308 → ld_hazard = 0. After the ack of the 0x304 store, the load at 0x306 gives ld_hazard = 0.
- 3 entries pending with mem_req high; assert reset between edges → mem_req and count go to 0 immediately. After release, a new store drains normally.
